// File: rtl/fsm_pkg.sv
// Shared constants and width helpers for the edge-driven mode sequencer.
// Legality checks are applied at elaboration time by the top level.
package fsm_pkg;

  localparam int IDLE = 0;

  function automatic int sw(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic int cw(input int t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction

  function automatic bit num_states_ok(input int n);
    return n >= 2;
  endfunction

endpackage

// File: rtl/edge_mode_sequencer_if.sv
// Output bundle of the mode sequencer: state index, LED decode, event pulses.
// The sequencer drives the master side; consumers attach to the slave side.
interface edge_mode_sequencer_if
  import fsm_pkg::*;
#(
  parameter int NUM_STATES = 3
);

  localparam int SW = sw(NUM_STATES);

  logic [SW-1:0]         state_o;
  logic [NUM_STATES-1:0] led_o;
  logic                  adv_o;
  logic                  wrap_o;
  logic                  timeout_o;
  logic                  drop_o;

  modport master (
    output state_o,
    output led_o,
    output adv_o,
    output wrap_o,
    output timeout_o,
    output drop_o
  );

  modport slave (
    input state_o,
    input led_o,
    input adv_o,
    input wrap_o,
    input timeout_o,
    input drop_o
  );

endinterface

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser, history flop and registered rising-edge pulse.
// Flops reset high so an input held high through reset gives no edge.
module sync_edge_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_din,
  output logic o_edge
);

  logic r_s1;
  logic r_s2;
  logic r_s3;
  logic r_edge;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1   <= 1'b1;
      r_s2   <= 1'b1;
      r_s3   <= 1'b1;
      r_edge <= 1'b0;
    end else begin
      r_s1   <= i_din;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_edge <= r_s2 & ~r_s3;
    end
  end

  assign o_edge = r_edge;

endmodule

// File: rtl/edge_mode_sequencer.sv
// Edge-driven circular mode sequencer with lockout and idle timeout.
// Drives the LED/indicator path through edge_mode_sequencer_if.
module edge_mode_sequencer
  import fsm_pkg::*;
#(
  parameter int NUM_STATES = 3,
  parameter int TIMEOUT    = 1000,
  parameter int LOCKOUT    = 4
) (
  input logic                   CLK_IN,
  input logic                   rst,
  input logic                   DATA_IN,
  edge_mode_sequencer_if.master bus
);

  localparam int SW = sw(NUM_STATES);
  localparam int TW = cw(TIMEOUT);
  localparam int LW = cw(LOCKOUT);
  localparam bit T_EN = (TIMEOUT > 0);

  localparam logic [SW-1:0] ST_IDLE = SW'(IDLE);
  localparam logic [SW-1:0] ST_LAST = SW'(NUM_STATES - 1);
  localparam logic [TW-1:0] T_END   = TW'(T_EN ? TIMEOUT - 1 : 0);
  localparam logic [LW-1:0] L_LOAD  = LW'(LOCKOUT);

  if (!num_states_ok(NUM_STATES)) begin : g_bad_states
    $error("edge_mode_sequencer: NUM_STATES must be at least 2");
  end

  logic                  w_edge;
  logic                  w_accept;
  logic                  w_drop;
  logic                  w_last;
  logic                  w_tmo;
  logic [SW-1:0]         w_next;
  logic [SW-1:0]         w_state_d;
  logic [NUM_STATES-1:0] w_led;

  logic [SW-1:0]         r_state;
  logic [LW-1:0]         r_lock;
  logic [TW-1:0]         r_tcnt;
  logic                  r_adv;
  logic                  r_wrap;
  logic                  r_tmo;
  logic                  r_drop;

  sync_edge_detect u_sync (
    .i_clk  (CLK_IN),
    .i_rst  (rst),
    .i_din  (DATA_IN),
    .o_edge (w_edge)
  );

  assign w_accept = w_edge && (r_lock == '0);
  assign w_drop   = w_edge && (r_lock != '0);
  assign w_last   = (r_state == ST_LAST);
  assign w_next   = w_last ? ST_IDLE : r_state + SW'(1);

  // An accepted edge in the expiry cycle wins over the timeout.
  assign w_tmo = T_EN
              && (r_state != ST_IDLE)
              && (r_tcnt == T_END)
              && !w_accept;

  always_comb begin
    w_state_d = r_state;
    unique case (1'b1)
      w_accept: w_state_d = w_next;
      w_tmo:    w_state_d = ST_IDLE;
      default:  ;
    endcase
  end

  always_ff @(posedge CLK_IN) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_adv   <= 1'b0;
      r_wrap  <= 1'b0;
      r_tmo   <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_adv   <= w_accept;
      r_wrap  <= w_accept && w_last;
      r_tmo   <= w_tmo;
      r_drop  <= w_drop;
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (rst) begin
      r_lock <= '0;
    end else if (w_accept) begin
      r_lock <= L_LOAD;
    end else if (r_lock != '0) begin
      r_lock <= r_lock - LW'(1);
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (rst) begin
      r_tcnt <= '0;
    end else if (!T_EN || w_accept || w_tmo || r_state == ST_IDLE) begin
      r_tcnt <= '0;
    end else begin
      r_tcnt <= r_tcnt + TW'(1);
    end
  end

  always_comb begin
    w_led          = '0;
    w_led[r_state] = 1'b1;
  end

  assign bus.state_o   = r_state;
  assign bus.led_o     = w_led;
  assign bus.adv_o     = r_adv;
  assign bus.wrap_o    = r_wrap;
  assign bus.timeout_o = r_tmo;
  assign bus.drop_o    = r_drop;

endmodule

// File: tb/tb_edge_mode_sequencer.sv
// Scoreboard bench for edge_mode_sequencer: directed pulses push expected
// events; a negedge monitor pops and compares whenever a pulse output fires.
module tb_edge_mode_sequencer;

  typedef struct {
    int         cyc;
    logic [1:0] st;
    logic       adv;
    logic       wrap;
    logic       tmo;
    logic       drop;
  } exp_t;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic din  = 1'b0;
  logic din0 = 1'b0;

  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;
  int   tmo0  = 0;
  int   adv0  = 0;
  exp_t q[$];
  exp_t e;
  logic [3:0] el;

  always #5 clk = ~clk;

  edge_mode_sequencer_if #(.NUM_STATES(4)) ifa ();
  edge_mode_sequencer_if #(.NUM_STATES(4)) ifz ();

  edge_mode_sequencer #(
    .NUM_STATES (4),
    .TIMEOUT    (20),
    .LOCKOUT    (4)
  ) dut (
    .CLK_IN  (clk),
    .rst     (rst),
    .DATA_IN (din),
    .bus     (ifa)
  );

  edge_mode_sequencer #(
    .NUM_STATES (4),
    .TIMEOUT    (0),
    .LOCKOUT    (4)
  ) dut0 (
    .CLK_IN  (clk),
    .rst     (rst),
    .DATA_IN (din0),
    .bus     (ifz)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ifz.timeout_o) tmo0++;
    if (ifz.adv_o) adv0++;
  end

  always @(negedge clk) begin
    if (ifa.adv_o | ifa.wrap_o | ifa.timeout_o | ifa.drop_o) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event cyc=%0d st=%0d adv=%b wrap=%b tmo=%b drop=%b",
                 cyc, ifa.state_o, ifa.adv_o, ifa.wrap_o,
                 ifa.timeout_o, ifa.drop_o);
      end else begin
        e  = q.pop_front();
        el = 4'b0001 << e.st;
        if (cyc !== e.cyc || ifa.state_o !== e.st || ifa.led_o !== el
            || ifa.adv_o !== e.adv || ifa.wrap_o !== e.wrap
            || ifa.timeout_o !== e.tmo || ifa.drop_o !== e.drop) begin
          fails++;
          $display("FAIL event got cyc=%0d st=%0d led=%b a/w/t/d=%b%b%b%b exp cyc=%0d st=%0d led=%b a/w/t/d=%b%b%b%b",
                   cyc, ifa.state_o, ifa.led_o, ifa.adv_o, ifa.wrap_o,
                   ifa.timeout_o, ifa.drop_o, e.cyc, e.st, el,
                   e.adv, e.wrap, e.tmo, e.drop);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int hold, output int k);
    din = 1'b1;
    k   = cyc + 1;
    repeat (hold) @(negedge clk);
    din = 1'b0;
  endtask

  task automatic ev(input int c, input int st, input logic a,
                    input logic w, input logic t, input logic d);
    exp_t x;
    x.cyc  = c;
    x.st   = 2'(st);
    x.adv  = a;
    x.wrap = w;
    x.tmo  = t;
    x.drop = d;
    q.push_back(x);
  endtask

  initial begin
    int k;
    int k2;
    gap(3);
    chk("rst_state", 32'(ifa.state_o), 0);
    chk("rst_led", 32'(ifa.led_o), 32'h1);
    chk("rst_pulses", 32'({ifa.adv_o, ifa.wrap_o, ifa.timeout_o, ifa.drop_o}), 0);
    rst = 1'b0;
    gap(3);

    for (int i = 0; i < 4; i++) begin
      pulse(3, k);
      ev(k + 3, (i + 1) % 4, 1, i == 3, 0, 0);
      gap(7);
    end
    gap(5);

    pulse(2, k);
    ev(k + 3, 1, 1, 0, 0, 0);
    gap(1);
    pulse(2, k2);
    ev(k2 + 3, 1, 0, 0, 0, 1);
    ev(k + 23, 0, 0, 0, 1, 0);
    gap(3);
    chk("drop_hold", 32'(ifa.state_o), 1);
    gap(25);
    chk("tmo_idle", 32'(ifa.state_o), 0);

    pulse(2, k);
    ev(k + 3, 1, 1, 0, 0, 0);
    gap(3);
    pulse(2, k2);
    ev(k2 + 3, 2, 1, 0, 0, 0);
    ev(k2 + 23, 0, 0, 0, 1, 0);
    gap(30);

    pulse(3, k);
    ev(k + 3, 1, 1, 0, 0, 0);
    gap(17);
    pulse(3, k2);
    ev(k2 + 3, 2, 1, 0, 0, 0);
    ev(k2 + 23, 0, 0, 0, 1, 0);
    gap(30);

    pulse(3, k);
    ev(k + 3, 1, 1, 0, 0, 0);
    gap(7);
    pulse(3, k2);
    ev(k2 + 3, 2, 1, 0, 0, 0);
    gap(1);
    chk("pre_rst_state", 32'(ifa.state_o), 2);
    rst = 1'b1;
    gap(1);
    chk("mid_rst_state", 32'(ifa.state_o), 0);
    chk("mid_rst_led", 32'(ifa.led_o), 32'h1);
    chk("mid_rst_pulses", 32'({ifa.adv_o, ifa.wrap_o, ifa.timeout_o, ifa.drop_o}), 0);
    chk("mid_rst_sb", 32'(q.size()), 0);
    rst = 1'b0;
    gap(1);
    pulse(3, k);
    ev(k + 3, 1, 1, 0, 0, 0);
    ev(k + 23, 0, 0, 0, 1, 0);
    gap(30);

    din = 1'b1;
    rst = 1'b1;
    gap(2);
    rst = 1'b0;
    gap(5);
    chk("hi_rst_state", 32'(ifa.state_o), 0);
    din = 1'b0;
    gap(2);
    pulse(3, k);
    ev(k + 3, 1, 1, 0, 0, 0);
    ev(k + 23, 0, 0, 0, 1, 0);
    gap(30);

    din0 = 1'b1;
    gap(3);
    din0 = 1'b0;
    gap(60);
    chk("t0_state", 32'(ifz.state_o), 1);
    chk("t0_led", 32'(ifz.led_o), 32'h2);
    chk("t0_no_tmo", 32'(tmo0), 0);
    chk("t0_adv_cnt", 32'(adv0), 1);

    chk("sb_empty", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
